// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side bus of the UART transmitter.
//   i_data  : word to queue (DATA_BITS wide)
//   i_valid : producer offers i_data
//   o_ready : FIFO can accept a word
//   o_level : words waiting in the FIFO (excludes the frame on the line)
//   o_idle  : FIFO empty and no frame in progress
// master = producer, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic [LevelW-1:0]    o_level;
  logic                 o_idle;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_level,
    input  o_idle
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_level,
    output o_idle
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO. Frame format is
// start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop
// bits; every bit lasts exactly CLK_FREQ / BAUD clocks. Frames are sent
// back-to-back while the FIFO holds data.
//   i_clk : clock
//   i_rst : synchronous active-high reset (aborts any frame, flushes FIFO)
//   bus   : producer handshake (uart_tx_fifo_if.slave)
//   o_out : registered serial line, idle high
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ  = 250000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  uart_tx_fifo_if.slave    bus,
  output logic             o_out
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned IdxW       = $clog2(DATA_BITS + 1);
  localparam int unsigned PtrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LevelW     = $clog2(DEPTH + 1);

  localparam logic [CntW-1:0]   CntLast   = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0]   DataLast  = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0]   StopLast  = IdxW'(STOP_BITS - 1);
  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);

  // Elaboration-time parameter checks.
  if (ClksPerBit < 2) begin : g_chk_baud
    $error("uart_tx_fifo: CLK_FREQ / BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_chk_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]    level_q;

  // Transmitter
  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 out_q;

  logic                 push, pop, fifo_empty, bit_end, stop_end;
  logic [DATA_BITS-1:0] head;
  logic                 head_parity;

  assign fifo_empty  = (level_q == '0);
  assign push        = bus.i_valid && bus.o_ready;
  assign bit_end     = (cnt_q == CntLast);
  assign stop_end    = (state_q == StStop) && bit_end && (idx_q == StopLast);
  // Pop either from idle or exactly at the end of the last stop bit, so the
  // next start bit follows with no idle cycle.
  assign pop         = !fifo_empty && ((state_q == StIdle) || stop_end);
  assign head        = mem_q[rd_ptr_q];
  assign head_parity = (^head) ^ (PARITY == 2);

  assign bus.o_ready = (level_q != LevelFull);
  assign bus.o_level = level_q;
  assign bus.o_idle  = (state_q == StIdle) && fifo_empty;
  assign o_out       = out_q;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tells full from empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          out_q <= 1'b1;
          if (pop) begin
            state_q  <= StStart;
            cnt_q    <= '0;
            shift_q  <= head;
            parity_q <= head_parity;
            out_q    <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StData;
            out_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == DataLast) begin
              if (PARITY != 0) begin
                state_q <= StParity;
                out_q   <= parity_q;
              end else begin
                state_q <= StStop;
                idx_q   <= '0;
                out_q   <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_q >> 1;
              out_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StStop;
            out_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == StopLast) begin
              if (pop) begin
                state_q  <= StStart;
                shift_q  <= head;
                parity_q <= head_parity;
                out_q    <= 1'b0;
              end else begin
                state_q <= StIdle;
                out_q   <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          out_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four uart_tx_fifo instances (8N1, 8E1, 8O1, 9N2) at
// 8 clocks per bit, driven together and checked every cycle against a
// queue-based model of the line, plus literal expectations for key points.
module tb_uart_tx_fifo;

  localparam int NI    = 4;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int DB [NI] = '{8, 8, 8, 9};
  localparam int PA [NI] = '{0, 1, 2, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};
  localparam int FL [NI] = '{80, 88, 88, 96};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] drv_data  [NI];
  logic       drv_valid [NI];
  logic       line_w    [NI];
  logic       ready_w   [NI];
  logic       idle_w    [NI];
  logic [2:0] level_w   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queued words, remaining line samples of the current frame.
  int m_fifo [NI][$];
  bit m_rem  [NI][$];
  bit m_busy [NI];
  bit m_out  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo_if #(.DATA_BITS(DB[g]), .DEPTH(DEPTH)) bus ();
    assign bus.i_data  = drv_data[g][DB[g]-1:0];
    assign bus.i_valid = drv_valid[g];
    assign ready_w[g]  = bus.o_ready;
    assign idle_w[g]   = bus.o_idle;
    assign level_w[g]  = bus.o_level;

    uart_tx_fifo #(
      .CLK_FREQ (80),
      .BAUD     (10),
      .DATA_BITS(DB[g]),
      .PARITY   (PA[g]),
      .STOP_BITS(SB[g]),
      .DEPTH    (DEPTH)
    ) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus),
      .o_out(line_w[g])
    );
  end

  task automatic check(input string name, input int g, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0d, expected %0d", name, g, $time, act, exp);
    end
  endtask

  function automatic void load_frame(input int g, input int w);
    int p;
    p = 0;
    for (int k = 0; k < CPB; k++) m_rem[g].push_back(1'b0);
    for (int b = 0; b < DB[g]; b++) begin
      p = p ^ ((w >> b) & 1);
      for (int k = 0; k < CPB; k++) m_rem[g].push_back(bit'((w >> b) & 1));
    end
    if (PA[g] != 0) begin
      if (PA[g] == 2) p = p ^ 1;
      for (int k = 0; k < CPB; k++) m_rem[g].push_back(bit'(p));
    end
    for (int k = 0; k < SB[g] * CPB; k++) m_rem[g].push_back(1'b1);
  endfunction

  task automatic step_model();
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_fifo[g].delete();
        m_rem[g].delete();
        m_busy[g] = 1'b0;
        m_out[g]  = 1'b1;
      end else begin
        bit do_push;
        do_push = drv_valid[g] && (m_fifo[g].size() < DEPTH);
        if (m_rem[g].size() == 0) begin
          if (m_fifo[g].size() > 0) begin
            load_frame(g, m_fifo[g].pop_front());
            m_busy[g] = 1'b1;
            m_out[g]  = m_rem[g].pop_front();
          end else begin
            m_busy[g] = 1'b0;
            m_out[g]  = 1'b1;
          end
        end else begin
          m_out[g] = m_rem[g].pop_front();
        end
        if (do_push) m_fifo[g].push_back(int'(drv_data[g]) & ((1 << DB[g]) - 1));
      end
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < NI; g++) begin
      check("out", g, int'(line_w[g]), int'(m_out[g]));
      check("level", g, int'(level_w[g]), m_fifo[g].size());
      check("ready", g, int'(ready_w[g]), (m_fifo[g].size() < DEPTH) ? 1 : 0);
      check("idle", g, int'(idle_w[g]), (!m_busy[g] && m_fifo[g].size() == 0) ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] cap [NI];
    logic [11:0] exp_cap [NI];
    int nxt [NI];
    int first [NI];
    int done [NI];
    bit acc [NI];
    int ff_cycles;
    int cyc;
    bit all_done;

    exp_cap = '{12'hF4A, 12'hE0E, 12'hC0E, 12'hFFE};
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      drv_valid[g] = 1'b0;
      drv_data[g]  = '0;
      cap[g]       = '0;
    end

    // Reset state
    repeat (3) tick();
    check("rst_out", 0, int'(line_w[0]), 1);
    check("rst_ready", 0, int'(ready_w[0]), 1);
    check("rst_idle", 0, int'(idle_w[0]), 1);
    check("rst_level", 0, int'(level_w[0]), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single frame on every instance
    drv_data[0] = 9'h0A5;
    drv_data[1] = 9'h007;
    drv_data[2] = 9'h007;
    drv_data[3] = 9'h1FF;
    for (int g = 0; g < NI; g++) drv_valid[g] = 1'b1;
    tick();
    check("level_after_push", 0, int'(level_w[0]), 1);
    for (int g = 0; g < NI; g++) drv_valid[g] = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      tick();
      if (c == 1) begin
        check("start_low", 0, int'(line_w[0]), 0);
        check("level_after_pop", 0, int'(level_w[0]), 0);
        check("idle_after_pop", 0, int'(idle_w[0]), 0);
      end
      for (int g = 0; g < NI; g++) begin
        if ((c - 1) % CPB == CPB / 2 && (c - 1) / CPB < 12) cap[g][(c - 1) / CPB] = line_w[g];
        if (c == FL[g]) check("frame_busy_last", g, int'(idle_w[g]), 0);
        if (c == FL[g] + 1) check("frame_idle_after", g, int'(idle_w[g]), 1);
      end
    end
    for (int g = 0; g < NI; g++) check("frame_bits", g, int'(cap[g]), int'(exp_cap[g]));

    // Burst of six words; afterwards offer 0xFF on dut0 while full
    ff_cycles = 0;
    cyc = 0;
    for (int g = 0; g < NI; g++) begin
      nxt[g]   = 0;
      first[g] = -1;
      done[g]  = -1;
    end
    all_done = 1'b0;
    while (cyc < 900 && !all_done) begin
      for (int g = 0; g < NI; g++) begin
        if (nxt[g] < 6) begin
          drv_valid[g] = 1'b1;
          drv_data[g]  = 9'(nxt[g] + 1);
        end else if (g == 0 && ff_cycles < 20 && !ready_w[0]) begin
          drv_valid[g] = 1'b1;
          drv_data[g]  = 9'h0FF;
          ff_cycles++;
        end else begin
          drv_valid[g] = 1'b0;
        end
        acc[g] = drv_valid[g] && ready_w[g] && (nxt[g] < 6);
      end
      tick();
      cyc++;
      all_done = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (acc[g]) nxt[g]++;
        if (first[g] < 0 && line_w[g] == 1'b0) first[g] = cyc;
        if (first[g] >= 0 && done[g] < 0 && idle_w[g]) done[g] = cyc;
        if (done[g] < 0) all_done = 1'b0;
      end
    end
    for (int g = 0; g < NI; g++) drv_valid[g] = 1'b0;
    check("full_offer_cycles", 0, ff_cycles, 20);
    for (int g = 0; g < NI; g++) check("burst_len", g, done[g] - first[g], 6 * FL[g]);

    // Reset during data bit 3 with two words queued; push during reset is dropped
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < NI; g++) begin
        drv_valid[g] = 1'b1;
        drv_data[g]  = 9'(8'h11 * (k + 1));
      end
      tick();
    end
    for (int g = 0; g < NI; g++) drv_valid[g] = 1'b0;
    repeat (33) tick();
    check("pre_rst_level", 0, int'(level_w[0]), 2);
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      drv_valid[g] = 1'b1;
      drv_data[g]  = 9'h055;
    end
    tick();
    rst = 1'b0;
    for (int g = 0; g < NI; g++) drv_valid[g] = 1'b0;
    check("abort_out", 0, int'(line_w[0]), 1);
    check("abort_level", 0, int'(level_w[0]), 0);
    check("abort_idle", 0, int'(idle_w[0]), 1);
    check("abort_ready", 0, int'(ready_w[0]), 1);
    for (int c = 0; c < 200; c++) begin
      tick();
      check("abort_hold_high", 0, int'(line_w[0]), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) and exact-length bit periods. It sits between a byte-producing core and the chip's serial TX pin. A producer can queue several words with a valid/ready handshake and return to other work. Frames leave the line back-to-back while the FIFO holds data.

## Interface
- CLK_FREQ, 250000: clock frequency in Hz.
- BAUD, 9600: line rate; CLKS_PER_BIT = CLK_FREQ / BAUD (integer division), must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- Illegal parameter values stop elaboration via `$error` in an initial/generate check.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  DATA_BITS  word to queue.
- i_valid  in  1  producer offers i_data.
- o_ready  out  1  FIFO can accept (level < DEPTH).
- o_level  out  $clog2(DEPTH+1)  words currently in FIFO; excludes the word being sent.
- o_idle  out  1  FIFO empty and no frame in progress.
- o_out  out  1  serial line, registered, idle high.

## Operation
- Push: i_valid && o_ready at a rising edge writes i_data to the FIFO tail. i_valid while o_ready = 0 is ignored, and the word is lost unless the producer holds it.
- Transmitter FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_out = 1. If the FIFO is non-empty at an edge, pop the head into the shift register, go to START, and load the bit counter.
- START: line 0 for CLKS_PER_BIT cycles.
- DATA: DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each.
- PARITY: present only if PARITY ≠ 0. Bit value is XOR of all data bits; inverted for odd. Lasts CLKS_PER_BIT cycles.
- STOP: line 1 for STOP_BITS × CLKS_PER_BIT cycles.
- End of STOP: if the FIFO is non-empty, pop and go straight to START with no idle cycle. Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles, exact.
- Simultaneous push and pop: both happen and o_level is unchanged. A push into an empty FIFO while the FSM is IDLE is popped on the next edge.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the level counter.
- Counters: the bit-period counter is wide enough for CLKS_PER_BIT − 1. The bit index is wide enough for DATA_BITS.

## Timing
- Reset values (the edge where i_rst = 1 takes effect): o_out = 1, o_ready = 1, o_idle = 1, o_level = 0. FSM goes to IDLE and the FIFO is flushed.
- Reset mid-frame aborts the frame. The line is high from the next cycle, with no partial bits or stop bit appended. Queued words are discarded.
- i_rst dominates a simultaneous push.
- Latency: word pushed at edge N into an empty FIFO with the FSM in IDLE:
  - o_level = 1 after edge N.
  - Pop at edge N+1: o_level = 0, o_out = 0, o_idle = 0 after edge N+1.
- o_idle returns to 1 on the edge that ends the last stop bit when the FIFO is empty.
- o_ready and o_level are registered-state functions, valid the cycle after each edge. o_ready falls the cycle o_level reaches DEPTH. It rises the cycle after a pop from a full FIFO.

## Test plan
Common setup: CLK_FREQ = 80, BAUD = 10 (CLKS_PER_BIT = 8), DEPTH = 4 unless noted.
- 8N1, push 0xA5 once -> o_out low 1 cycle after the push edge. Bits then read 0 | 1,0,1,0,0,1,0,1 | 1, each exactly 8 cycles, 80 cycles total. o_idle = 1 after the frame.
- PARITY = 1, push 0x07, then PARITY = 2, push 0x07 -> parity bit 1 (even) and 0 (odd). Frame is 88 cycles.
- Push 6 words (0x01–0x06) holding i_valid whenever o_ready -> o_ready deasserts when o_level = 4. All 6 frames appear in order with zero idle cycles between stop and start. Total 480 cycles.
- FIFO full, i_valid with 0xFF -> no write, o_level stays 4, and 0xFF never appears on the line.
- STOP_BITS = 2, DATA_BITS = 9, push 0x1FF -> 9 data ones, then high for 16 cycles. Frame is 96 cycles.
- Assert i_rst during data bit 3 of a frame with 2 words queued -> o_out = 1, o_level = 0, o_idle = 1, o_ready = 1 next cycle. The line stays high for 200 cycles.
